// File: rtl/bit_reverse_reorder.sv
// Streaming frame reorder for the FFT path: natural-order samples in, bit-reversed (or bypassed)
// frames out, ping-pong banked so a new frame can be written while the previous one drains.
module bit_reverse_reorder #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sync,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [LOG2N-1:0]  out_idx,
  output logic              sync_err
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  // Bank select is the MSB of the flat memory address.
  logic [DATA_W-1:0] r_mem [0:2*N-1];

  logic [1:0]        r_bank_full;
  logic [1:0]        r_mode_bank;
  logic              r_wr_bank;
  logic [LOG2N-1:0]  r_wr_cnt;
  logic              r_rd_bank;
  logic [LOG2N-1:0]  r_rd_cnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic [LOG2N-1:0]  r_out_idx;
  logic              r_sync_err;

  logic              w_accept;
  logic              w_resync;
  logic              w_frame_start;
  logic [LOG2N-1:0]  w_wr_addr;
  logic              w_load;
  logic [LOG2N-1:0]  w_rd_addr;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  assign in_ready      = !r_bank_full[r_wr_bank];
  assign w_accept      = in_valid && in_ready;
  assign w_resync      = w_accept && in_sync && (r_wr_cnt != '0);
  assign w_frame_start = w_accept && (w_resync || (r_wr_cnt == '0));
  assign w_wr_addr     = w_resync ? '0 : r_wr_cnt;
  assign w_load        = r_bank_full[r_rd_bank] && (!r_out_valid || out_ready);
  assign w_rd_addr     = r_mode_bank[r_rd_bank] ? r_rd_cnt : bitrev(r_rd_cnt);

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_idx   = r_out_idx;
  assign sync_err  = r_sync_err;

  // Sample storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[{r_wr_bank, w_wr_addr}] <= in_data;
    end
  end

  // The write side only touches a non-full bank and the read side only a full one,
  // so the set and clear of r_bank_full never collide on the same bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bank_full <= '0;
      r_mode_bank <= '0;
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_idx   <= '0;
      r_sync_err  <= 1'b0;
    end else begin
      r_sync_err <= w_resync;

      if (w_frame_start) begin
        r_mode_bank[r_wr_bank] <= mode;
      end
      if (w_accept) begin
        if (w_resync) begin
          r_wr_cnt <= LOG2N'(1);
        end else if (r_wr_cnt == LAST) begin
          r_bank_full[r_wr_bank] <= 1'b1;
          r_wr_bank              <= ~r_wr_bank;
          r_wr_cnt               <= '0;
        end else begin
          r_wr_cnt <= r_wr_cnt + LOG2N'(1);
        end
      end

      if (w_load) begin
        r_out_data  <= r_mem[{r_rd_bank, w_rd_addr}];
        r_out_idx   <= w_rd_addr;
        r_out_last  <= (r_rd_cnt == LAST);
        r_out_valid <= 1'b1;
        if (r_rd_cnt == LAST) begin
          r_bank_full[r_rd_bank] <= 1'b0;
          r_rd_bank              <= ~r_rd_bank;
          r_rd_cnt               <= '0;
        end else begin
          r_rd_cnt <= r_rd_cnt + LOG2N'(1);
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_reverse_reorder.sv
// Self-checking bench for bit_reverse_reorder at N=8: a frame-level queue model checks every
// valid output cycle, and directed scenarios pin ordering, latency, stalls, resync and reset.
module tb_bit_reverse_reorder;

  localparam int DATA_W = 16;
  localparam int LOG2N  = 3;
  localparam int N      = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_sync = 1'b0;
  logic              mode = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [LOG2N-1:0]  out_idx;
  logic              sync_err;

  bit_reverse_reorder #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sync(in_sync), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_idx(out_idx), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [LOG2N-1:0]  idx;
    logic              last;
  } exp_t;

  exp_t              expQ[$];
  logic [DATA_W-1:0] curQ[$];
  logic              curMode = 1'b0;
  logic              expSyncErr = 1'b0;
  logic              prevValid = 1'b0;
  logic [DATA_W-1:0] capData[$];
  logic              capLast[$];

  int nCompared = 0, nMismatched = 0;
  int cyc = 0, accCount = 0, xferCount = 0, syncErrCount = 0, stallCount = 0;
  int riseCyc = -1, lastAccCyc = -1, firstXferCyc = -1, lastXferCyc = -1;

  logic [DATA_W-1:0] revOrder [N] = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};

  // Reversal by repeated halving, independent of any bit-slicing.
  function automatic int revIdx(input int p);
    int r = 0;
    int x = p;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] capAt(input int i);
    if (i < capData.size()) return capData[i];
    return 'x;
  endfunction

  function automatic logic capLastAt(input int i);
    if (i < capLast.size()) return capLast[i];
    return 1'bx;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic s, input logic m);
    int waitCyc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sync  = s;
    mode     = m;
    while (!in_ready && waitCyc < 200) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    if (waitCyc >= 200) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic stopInput();
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic idle(input int n);
    stopInput();
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic sendFrame(input logic [DATA_W-1:0] base, input logic m);
    for (int i = 0; i < N; i++) begin
      applyStimulus(base + DATA_W'(i), (i == 0), m);
    end
  endtask

  task automatic waitXfers(input int target);
    int b = 0;
    while (xferCount < target && b < 500) begin
      @(posedge clk); #1;
      b++;
    end
    checkOutput("drain_count", 32'(xferCount), 32'(target));
  endtask

  task automatic clearCapture();
    capData.delete();
    capLast.delete();
  endtask

  // Frame-level model: collect accepted samples per frame, then queue the expected emission order.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      expQ.delete();
      curQ.delete();
      expSyncErr = 1'b0;
      prevValid  = 1'b0;
    end else begin
      checkOutput("sync_err", 32'(sync_err), 32'(expSyncErr));
      if (sync_err === 1'b1) syncErrCount++;
      if (out_valid === 1'b1 && !prevValid) riseCyc = cyc;
      prevValid = (out_valid === 1'b1);

      if (out_valid !== 1'b0) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          checkOutput("out_data", 32'(out_data), 32'(expQ[0].data));
          checkOutput("out_idx", 32'(out_idx), 32'(expQ[0].idx));
          checkOutput("out_last", 32'(out_last), 32'(expQ[0].last));
          if (out_ready) begin
            void'(expQ.pop_front());
            xferCount++;
            capData.push_back(out_data);
            capLast.push_back(out_last);
            if (firstXferCyc < 0) firstXferCyc = cyc;
            lastXferCyc = cyc;
          end
        end
      end

      expSyncErr = 1'b0;
      if (in_valid && !in_ready) stallCount++;
      if (in_valid && in_ready) begin
        accCount++;
        lastAccCyc = cyc;
        if (in_sync && curQ.size() != 0) begin
          curQ.delete();
          expSyncErr = 1'b1;
        end
        if (curQ.size() == 0) curMode = mode;
        curQ.push_back(in_data);
        if (curQ.size() == N) begin
          for (int p = 0; p < N; p++) begin
            exp_t e;
            int a;
            a = curMode ? p : revIdx(p);
            e.data = curQ[a];
            e.idx  = LOG2N'(a);
            e.last = (p == N - 1);
            expQ.push_back(e);
          end
          curQ.delete();
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int accBase, xb, se;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_out_idx", 32'(out_idx), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    $display("[TB] T1 single bit-reversed ramp frame");
    clearCapture();
    xb = xferCount;
    sendFrame(16'd0, 1'b0);
    stopInput();
    accBase = lastAccCyc;
    waitXfers(xb + 8);
    checkOutput("t1_latency", 32'(riseCyc - accBase), 32'd2);
    for (int i = 0; i < N; i++) begin
      checkOutput("t1_order", 32'(capAt(i)), 32'(revOrder[i]));
      checkOutput("t1_last_flag", 32'(capLastAt(i)), 32'(i == N - 1));
    end

    $display("[TB] T2 four back-to-back frames");
    clearCapture();
    stallCount = 0;
    firstXferCyc = -1;
    xb = xferCount;
    for (int f = 1; f <= 4; f++) sendFrame(DATA_W'(16'h100 * f), 1'b0);
    stopInput();
    waitXfers(xb + 32);
    checkOutput("t2_no_stall", 32'(stallCount), 32'd0);
    checkOutput("t2_gap_free", 32'(lastXferCyc - firstXferCyc), 32'd31);
    checkOutput("t2_frame2_first", 32'(capAt(8)), 32'h200);
    checkOutput("t2_frame4_second", 32'(capAt(25)), 32'h404);

    $display("[TB] T3 backpressure with three frames");
    clearCapture();
    out_ready = 1'b0;
    accBase = accCount;
    xb = xferCount;
    fork
      begin
        for (int f = 3; f <= 5; f++) sendFrame(DATA_W'(16'h100 * f), 1'b0);
        stopInput();
      end
      begin
        int b = 0;
        while (accCount - accBase < 16 && b < 200) begin
          @(posedge clk); #1;
          b++;
        end
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("t3_in_ready_low", 32'(in_ready), 32'd0);
        checkOutput("t3_accepts", 32'(accCount - accBase), 32'd16);
        repeat (20) begin @(posedge clk); #1; end
        checkOutput("t3_held_valid", 32'(out_valid), 32'd1);
        checkOutput("t3_held_data", 32'(out_data), 32'h300);
        out_ready = 1'b1;
      end
    join
    waitXfers(xb + 24);
    checkOutput("t3_frame1_first", 32'(capAt(0)), 32'h300);
    checkOutput("t3_frame2_first", 32'(capAt(8)), 32'h400);
    checkOutput("t3_frame3_last", 32'(capAt(23)), 32'h507);

    $display("[TB] T4 bypass frame then bit-reverse frame with mid-frame mode change");
    clearCapture();
    xb = xferCount;
    sendFrame(16'h40, 1'b1);
    for (int i = 0; i < N; i++) applyStimulus(16'h50 + DATA_W'(i), (i == 0), (i >= 3));
    stopInput();
    waitXfers(xb + 16);
    for (int i = 0; i < N; i++) begin
      checkOutput("t4_bypass", 32'(capAt(i)), 32'h40 + 32'(i));
      checkOutput("t4_reversed", 32'(capAt(8 + i)), 32'h50 + 32'(revOrder[i]));
    end

    $display("[TB] T5 resync mid-frame");
    clearCapture();
    se = syncErrCount;
    xb = xferCount;
    applyStimulus(16'h80, 1'b1, 1'b0);
    applyStimulus(16'h81, 1'b0, 1'b0);
    applyStimulus(16'h82, 1'b0, 1'b0);
    applyStimulus(16'h90, 1'b1, 1'b0);
    for (int i = 1; i < N; i++) applyStimulus(16'h90 + DATA_W'(i), 1'b0, 1'b0);
    stopInput();
    waitXfers(xb + 8);
    idle(6);
    checkOutput("t5_sync_err_pulses", 32'(syncErrCount - se), 32'd1);
    checkOutput("t5_first", 32'(capAt(0)), 32'h90);
    checkOutput("t5_second", 32'(capAt(1)), 32'h94);
    checkOutput("t5_total", 32'(xferCount - xb), 32'd8);

    $display("[TB] T6 reset during drain");
    xb = xferCount;
    sendFrame(16'hA0, 1'b0);
    applyStimulus(16'hB0, 1'b1, 1'b0);
    applyStimulus(16'hB1, 1'b0, 1'b0);
    applyStimulus(16'hB2, 1'b0, 1'b0);
    stopInput();
    begin
      int b = 0;
      while (xferCount - xb < 4 && b < 100) begin
        @(posedge clk); #1;
        b++;
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_out_last", 32'(out_last), 32'd0);
    checkOutput("t6_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    clearCapture();
    xb = xferCount;
    sendFrame(16'hC0, 1'b0);
    stopInput();
    waitXfers(xb + 8);
    idle(6);
    checkOutput("t6_first", 32'(capAt(0)), 32'hC0);
    checkOutput("t6_second", 32'(capAt(1)), 32'hC4);
    checkOutput("t6_last", 32'(capAt(7)), 32'hC7);
    checkOutput("t6_total", 32'(xferCount - xb), 32'd8);

    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
